// File: rtl/vbs_capture.sv
// Composite-video sync/pixel receiver: recovers line and frame timing from the sync stream
// and writes the packed active pixels into a frame RAM through a write-strobe port.
module vbs_capture #(
    parameter int unsigned GLITCH       = 4,
    parameter int unsigned VSYNC_MIN    = 256,
    parameter int unsigned VSYNC_LINE   = 3,
    parameter int unsigned FIRST_LINE   = 35,
    parameter int unsigned ROWS         = 192,
    parameter int unsigned X_START      = 94,
    parameter int unsigned BYTES        = 40,
    parameter int unsigned LINE_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        sync,
    input  logic        pixel,
    output logic [12:0] wAddr,
    output logic [7:0]  wData,
    output logic        wStrobe,
    output logic        locked,
    output logic        frameDone
);

    typedef enum logic [1:0] {StHunt, StArmed, StLocked} state_e;

    localparam logic [8:0]  LowMax    = 9'd511;
    localparam logic [8:0]  GlitchM1  = 9'(GLITCH - 1);
    localparam logic [8:0]  VsyncM1   = 9'(VSYNC_MIN - 1);
    localparam logic [9:0]  HLoad     = 10'(GLITCH);
    localparam logic [9:0]  HMax      = 10'd1023;
    localparam logic [9:0]  XStart    = 10'(X_START);
    localparam logic [9:0]  XEnd      = 10'(X_START + 8 * BYTES);
    localparam logic [6:0]  LastByte  = 7'(BYTES - 1);
    localparam logic [8:0]  LineVs    = 9'(VSYNC_LINE);
    localparam logic [8:0]  LineFirst = 9'(FIRST_LINE);
    localparam logic [8:0]  LineEnd   = 9'(FIRST_LINE + ROWS);
    localparam logic [10:0] TMax      = 11'(LINE_TIMEOUT - 1);
    localparam logic [7:0]  RowLast   = 8'(ROWS - 1);
    // Skip from the end of the third row of a group to the next 128-byte group boundary.
    localparam logic [12:0] GroupStep = 13'(128 - 3 * BYTES + 1);

    // Input synchronizers (both inputs share the same latency)
    logic sync_meta, sync_s, pix_meta, pix_s;

    // Timing recovery
    logic [8:0]  low_run_q, low_run_d;
    logic [9:0]  hcnt_q, hcnt_d;
    logic [8:0]  line_q, line_d;
    logic [10:0] tcnt_q, tcnt_d;
    logic        edge_det, vsync_det, timeout;
    logic [9:0]  rel;
    logic        in_window, active_line, capture;

    // Control and capture
    state_e      state_q, state_d;
    logic        locked_q, locked_d;
    logic        start;
    logic [6:0]  shift_q, shift_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        wstrobe_q, wstrobe_d;
    logic        last_q, last_d;
    logic [12:0] waddr_q, waddr_d;
    logic [1:0]  rig_q, rig_d;
    logic [7:0]  row_q, row_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_full_q, frame_full_d;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync_meta <= 1'b1;
            sync_s    <= 1'b1;
            pix_meta  <= 1'b0;
            pix_s     <= 1'b0;
        end else begin
            sync_meta <= sync;
            sync_s    <= sync_meta;
            pix_meta  <= pixel;
            pix_s     <= pix_meta;
        end
    end

    // An edge is confirmed on the GLITCH-th consecutive low sample.
    assign edge_det    = !sync_s && (low_run_q == GlitchM1);
    assign vsync_det   = !sync_s && (low_run_q == VsyncM1);
    assign timeout     = !edge_det && (tcnt_q == TMax);
    assign rel         = hcnt_q - XStart;
    assign in_window   = (hcnt_q >= XStart) && (hcnt_q < XEnd);
    assign active_line = (line_q >= LineFirst) && (line_q < LineEnd);
    assign capture     = (state_q == StLocked) && active_line && !frame_full_q &&
                         in_window && !timeout;

    always_comb begin
        low_run_d = low_run_q;
        hcnt_d    = hcnt_q;
        line_d    = line_q;
        tcnt_d    = tcnt_q;

        if (sync_s) begin
            low_run_d = '0;
        end else if (low_run_q != LowMax) begin
            low_run_d = low_run_q + 9'd1;
        end

        // hcnt_q tracks the sample position, so the confirming sample is GLITCH-1
        if (edge_det) begin
            hcnt_d = HLoad;
        end else if (hcnt_q != HMax) begin
            hcnt_d = hcnt_q + 10'd1;
        end

        if (vsync_det) begin
            line_d = LineVs;
        end else if (edge_det) begin
            line_d = line_q + 9'd1;
        end

        if (edge_det) begin
            tcnt_d = '0;
        end else if (tcnt_q != TMax) begin
            tcnt_d = tcnt_q + 11'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        locked_d = locked_q;
        start    = 1'b0;

        case (state_q)
            StHunt: begin
                if (vsync_det) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (edge_det) begin
                    state_d  = StLocked;
                    locked_d = 1'b1;
                    start    = 1'b1;
                end
            end
            StLocked: begin
                if (vsync_det) begin
                    state_d = StArmed;
                end
            end
            default: state_d = StHunt;
        endcase

        if (timeout) begin
            state_d  = StHunt;
            locked_d = 1'b0;
            start    = 1'b0;
        end
    end

    always_comb begin
        shift_d      = shift_q;
        wdata_d      = wdata_q;
        wstrobe_d    = 1'b0;
        last_d       = last_q;
        waddr_d      = waddr_q;
        rig_d        = rig_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        frame_full_d = frame_full_q;

        if (capture) begin
            shift_d = {shift_q[5:0], ~pix_s};
            if (rel[2:0] == 3'd7) begin
                wdata_d   = {shift_q, ~pix_s};
                wstrobe_d = 1'b1;
                last_d    = (rel[9:3] == LastByte);
            end
        end

        if (vsync_det) begin
            frame_full_d = 1'b0;
        end

        if (start) begin
            waddr_d = '0;
            rig_d   = '0;
            row_d   = '0;
        end else if (wstrobe_q) begin
            if (!last_q) begin
                waddr_d = waddr_q + 13'd1;
            end else if (row_q == RowLast) begin
                waddr_d      = '0;
                rig_d        = '0;
                row_d        = '0;
                frame_done_d = 1'b1;
                frame_full_d = 1'b1;
            end else begin
                waddr_d = waddr_q + ((rig_q == 2'd2) ? GroupStep : 13'd1);
                rig_d   = (rig_q == 2'd2) ? 2'd0 : rig_q + 2'd1;
                row_d   = row_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            low_run_q    <= '0;
            hcnt_q       <= '0;
            line_q       <= '0;
            tcnt_q       <= '0;
            state_q      <= StHunt;
            locked_q     <= 1'b0;
            shift_q      <= '0;
            wdata_q      <= '0;
            wstrobe_q    <= 1'b0;
            last_q       <= 1'b0;
            waddr_q      <= '0;
            rig_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
            frame_full_q <= 1'b0;
        end else begin
            low_run_q    <= low_run_d;
            hcnt_q       <= hcnt_d;
            line_q       <= line_d;
            tcnt_q       <= tcnt_d;
            state_q      <= state_d;
            locked_q     <= locked_d;
            shift_q      <= shift_d;
            wdata_q      <= wdata_d;
            wstrobe_q    <= wstrobe_d;
            last_q       <= last_d;
            waddr_q      <= waddr_d;
            rig_q        <= rig_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
            frame_full_q <= frame_full_d;
        end
    end

    assign wAddr     = waddr_q;
    assign wData     = wdata_q;
    assign wStrobe   = wstrobe_q;
    assign locked    = locked_q;
    assign frameDone = frame_done_q;

endmodule
